// File: rtl/updown_counter_pkg.sv
// Shared types for the up/down counter system: FSM state and step direction.
package updown_counter_pkg;

    typedef enum logic [2:0] {
        INICIO   = 3'd0,
        ESPERA   = 3'd1,
        VERIFICA = 3'd2,
        INC      = 3'd3,
        DEC      = 3'd4,
        HOLD     = 3'd5
    } state_e;

    typedef enum logic {
        OP_UP   = 1'b0,
        OP_DOWN = 1'b1
    } op_e;

endpackage

// File: rtl/updown_counter_if.sv
// Button/display bundle between the front-panel logic and the counter.
interface updown_counter_if #(
    parameter int WIDTH = 16
) ();
    logic             u;
    logic             d;
    logic             clr;
    logic [WIDTH-1:0] c_out;
    logic             z;
    logic             m;
    logic             lim;

    // Front panel side: drives requests, observes the count.
    modport master (
        output u, d, clr,
        input  c_out, z, m, lim
    );

    // Counter side.
    modport slave (
        input  u, d, clr,
        output c_out, z, m, lim
    );
endinterface

// File: rtl/updown_counter_dp.sv
// Counter datapath: count register, bounded step arithmetic, z/m/lim flags.
module updown_counter_dp
    import updown_counter_pkg::*;
#(
    parameter int              WIDTH   = 16,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned STEP    = 1,
    parameter int              WRAP    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_ld,
    input  op_e              i_op,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_z,
    output logic             o_m,
    output logic             o_lim
);

    localparam logic [WIDTH:0] MAXW  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] STEPW = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] RANGE = MAXW + (WIDTH+1)'(1);

    logic [WIDTH-1:0] r_cnt;
    logic             r_lim;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH-1:0] w_next;
    logic             w_hit;

    // Next count for one step, with range-end detection, in WIDTH+1 bits.
    always_comb begin
        w_ext  = {1'b0, r_cnt};
        w_next = r_cnt;
        w_hit  = 1'b0;
        if (i_op == OP_UP) begin
            if (w_ext > MAXW - STEPW) begin
                w_hit  = 1'b1;
                w_next = (WRAP != 0) ? WIDTH'(w_ext + STEPW - RANGE) : WIDTH'(MAXW);
            end else begin
                w_next = WIDTH'(w_ext + STEPW);
            end
        end else begin
            if (w_ext < STEPW) begin
                w_hit  = 1'b1;
                w_next = (WRAP != 0) ? WIDTH'(w_ext + RANGE - STEPW) : '0;
            end else begin
                w_next = WIDTH'(w_ext - STEPW);
            end
        end
    end

    // Count register; lim pulses in the same cycle the stepped value appears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_lim <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_lim <= 1'b0;
        end else if (i_ld) begin
            r_cnt <= w_next;
            r_lim <= w_hit;
        end else begin
            r_lim <= 1'b0;
        end
    end

    assign o_cnt = r_cnt;
    assign o_lim = r_lim;
    assign o_z   = (r_cnt == '0);
    assign o_m   = (r_cnt == WIDTH'(MAXW));

endmodule

// File: rtl/updown_counter_sys.sv
// Up/down counter system: button-handshake FSM driving the counter datapath.
module updown_counter_sys
    import updown_counter_pkg::*;
#(
    parameter int              WIDTH   = 16,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned STEP    = 1,
    parameter int              WRAP    = 0,
    parameter int              REPEAT  = 0
) (
    input  logic               clk,
    input  logic               reset,
    updown_counter_if.slave    bus
);

    localparam int             TW       = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [TW-1:0]  RPT_LAST = TW'(REPEAT - 1);

    state_e           r_state;
    logic             r_clr;
    logic             r_ld;
    op_e              r_op;
    logic [TW-1:0]    r_rpt;
    logic             r_blk;
    logic [WIDTH-1:0] w_cnt;
    logic             w_clr;
    logic             w_z;
    logic             w_m;
    logic             w_lim;

    // Control FSM; c_clr/c_ld/op are registered so they line up with INICIO/INC/DEC.
    // r_blk suppresses auto-repeat after a soft clear until both buttons are released.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INICIO;
            r_clr   <= 1'b1;
            r_ld    <= 1'b0;
            r_op    <= OP_UP;
            r_rpt   <= '0;
            r_blk   <= 1'b0;
        end else if (bus.clr) begin
            r_state <= HOLD;
            r_clr   <= 1'b0;
            r_ld    <= 1'b0;
            r_rpt   <= '0;
            r_blk   <= 1'b1;
        end else begin
            case (r_state)
                INICIO: begin
                    r_state <= ESPERA;
                    r_clr   <= 1'b0;
                end
                ESPERA: begin
                    r_state <= VERIFICA;
                end
                VERIFICA: begin
                    if (bus.u && !bus.d) begin
                        r_state <= INC;
                        r_ld    <= 1'b1;
                        r_op    <= OP_UP;
                    end else if (bus.d && !bus.u) begin
                        r_state <= DEC;
                        r_ld    <= 1'b1;
                        r_op    <= OP_DOWN;
                    end else if (bus.u && bus.d) begin
                        r_state <= HOLD;
                        r_rpt   <= '0;
                    end
                end
                INC, DEC: begin
                    r_state <= HOLD;
                    r_ld    <= 1'b0;
                    r_rpt   <= '0;
                end
                HOLD: begin
                    if (!bus.u && !bus.d) begin
                        r_state <= VERIFICA;
                        r_rpt   <= '0;
                        r_blk   <= 1'b0;
                    end else if ((REPEAT > 0) && !r_blk) begin
                        if (bus.u && bus.d) begin
                            r_rpt <= '0;
                        end else if (r_rpt == RPT_LAST) begin
                            r_rpt <= '0;
                            r_ld  <= 1'b1;
                            if (bus.u) begin
                                r_state <= INC;
                                r_op    <= OP_UP;
                            end else begin
                                r_state <= DEC;
                                r_op    <= OP_DOWN;
                            end
                        end else begin
                            r_rpt <= r_rpt + TW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= INICIO;
                    r_clr   <= 1'b1;
                    r_ld    <= 1'b0;
                end
            endcase
        end
    end

    assign w_clr = r_clr | bus.clr;

    updown_counter_dp #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP    (STEP),
        .WRAP    (WRAP)
    ) u_dp (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_ld   (r_ld),
        .i_op   (r_op),
        .o_cnt  (w_cnt),
        .o_z    (w_z),
        .o_m    (w_m),
        .o_lim  (w_lim)
    );

    assign bus.c_out = w_cnt;
    assign bus.z     = w_z;
    assign bus.m     = w_m;
    assign bus.lim   = w_lim;

endmodule

// File: tb/tb_updown_counter_sys.sv
// Directed bench for updown_counter_sys across four parameter sets.
module tb_updown_counter_sys;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    updown_counter_if #(.WIDTH(16)) if_a ();
    updown_counter_if #(.WIDTH(4))  if_b ();
    updown_counter_if #(.WIDTH(4))  if_c ();
    updown_counter_if #(.WIDTH(16)) if_d ();

    // A: defaults (16-bit, step 1, saturate, no repeat)
    updown_counter_sys #(.WIDTH(16)) u_a (.clk(clk), .reset(reset), .bus(if_a));
    // B: 4-bit, max 9, step 4, saturate
    updown_counter_sys #(.WIDTH(4), .MAX_VAL(9), .STEP(4), .WRAP(0)) u_b (.clk(clk), .reset(reset), .bus(if_b));
    // C: 4-bit, max 9, step 4, wrap
    updown_counter_sys #(.WIDTH(4), .MAX_VAL(9), .STEP(4), .WRAP(1)) u_c (.clk(clk), .reset(reset), .bus(if_c));
    // D: 16-bit, auto-repeat every 3 hold cycles
    updown_counter_sys #(.WIDTH(16), .REPEAT(3)) u_d (.clk(clk), .reset(reset), .bus(if_d));

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int exp_rep [20] = '{0,1,1,1,1, 2,2,2,2, 3,3,3,3, 4,4,4,4, 5,5,5};

    initial begin
        reset = 1'b1;
        if_a.u = 1'b0; if_a.d = 1'b0; if_a.clr = 1'b0;
        if_b.u = 1'b0; if_b.d = 1'b0; if_b.clr = 1'b0;
        if_c.u = 1'b0; if_c.d = 1'b0; if_c.clr = 1'b0;
        if_d.u = 1'b0; if_d.d = 1'b0; if_d.clr = 1'b0;

        // Reset then idle
        tick(10);
        chk("a_rst_cnt", 32'(if_a.c_out), 0);
        chk("a_rst_z",   32'(if_a.z), 1);
        chk("a_rst_m",   32'(if_a.m), 0);
        chk("a_rst_lim", 32'(if_a.lim), 0);
        reset = 1'b0;
        tick(2);
        chk("a_idle_cnt", 32'(if_a.c_out), 0);
        chk("a_idle_z",   32'(if_a.z), 1);

        // Single presses on A, first press 2 cycles after reset falls
        if_a.u = 1'b1;
        tick(1);
        chk("a_lat1", 32'(if_a.c_out), 0);
        tick(1);
        chk("a_lat2", 32'(if_a.c_out), 1);
        tick(3);
        if_a.u = 1'b0;
        tick(2);
        chk("a_one_step", 32'(if_a.c_out), 1);
        if_a.u = 1'b1;
        tick(5);
        if_a.u = 1'b0;
        tick(2);
        chk("a_press2", 32'(if_a.c_out), 2);
        if_a.d = 1'b1;
        tick(5);
        if_a.d = 1'b0;
        tick(2);
        chk("a_down", 32'(if_a.c_out), 1);
        chk("a_down_z", 32'(if_a.z), 0);

        // Both buttons: no change
        if_a.u = 1'b1; if_a.d = 1'b1;
        tick(6);
        if_a.u = 1'b0; if_a.d = 1'b0;
        tick(2);
        chk("a_both", 32'(if_a.c_out), 1);

        // B saturate: 0 -> 4 -> 8 -> 9
        if_b.u = 1'b1; tick(2);
        chk("b_up1", 32'(if_b.c_out), 4);
        chk("b_up1_lim", 32'(if_b.lim), 0);
        if_b.u = 1'b0; tick(2);
        if_b.u = 1'b1; tick(2);
        chk("b_up2", 32'(if_b.c_out), 8);
        chk("b_up2_lim", 32'(if_b.lim), 0);
        if_b.u = 1'b0; tick(2);
        if_b.u = 1'b1; tick(2);
        chk("b_up3", 32'(if_b.c_out), 9);
        chk("b_up3_lim", 32'(if_b.lim), 1);
        chk("b_up3_m", 32'(if_b.m), 1);
        if_b.u = 1'b0; tick(1);
        chk("b_lim_pulse", 32'(if_b.lim), 0);
        tick(1);

        // B soft clear, then down at 0 saturates
        if_b.clr = 1'b1; tick(1);
        chk("b_clr", 32'(if_b.c_out), 0);
        chk("b_clr_z", 32'(if_b.z), 1);
        if_b.clr = 1'b0; tick(1);
        if_b.d = 1'b1; tick(2);
        chk("b_dn0", 32'(if_b.c_out), 0);
        chk("b_dn0_lim", 32'(if_b.lim), 1);
        chk("b_dn0_z", 32'(if_b.z), 1);
        if_b.d = 1'b0; tick(2);

        // C wrap: 0 -> 4 -> 8 -> 2 -> 8
        if_c.u = 1'b1; tick(2); if_c.u = 1'b0; tick(2);
        if_c.u = 1'b1; tick(2);
        chk("c_up2", 32'(if_c.c_out), 8);
        chk("c_up2_lim", 32'(if_c.lim), 0);
        if_c.u = 1'b0; tick(2);
        if_c.u = 1'b1; tick(2);
        chk("c_wrap_up", 32'(if_c.c_out), 2);
        chk("c_wrap_up_lim", 32'(if_c.lim), 1);
        if_c.u = 1'b0; tick(2);
        if_c.d = 1'b1; tick(2);
        chk("c_wrap_dn", 32'(if_c.c_out), 8);
        chk("c_wrap_dn_lim", 32'(if_c.lim), 1);
        if_c.d = 1'b0; tick(2);

        // D auto-repeat: steps at cycles 2, 6, 10, 14, 18
        if_d.u = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            chk("d_repeat", 32'(if_d.c_out), 32'(exp_rep[k-1]));
        end
        if_d.u = 1'b0;
        tick(3);
        chk("d_repeat_final", 32'(if_d.c_out), 5);

        // D to 7 with short presses, then clear with u held
        if_d.u = 1'b1; tick(2); if_d.u = 1'b0; tick(2);
        if_d.u = 1'b1; tick(2); if_d.u = 1'b0; tick(2);
        chk("d_at7", 32'(if_d.c_out), 7);
        if_d.u = 1'b1; if_d.clr = 1'b1;
        tick(1);
        chk("d_clr", 32'(if_d.c_out), 0);
        if_d.clr = 1'b0;
        tick(10);
        chk("d_clr_held", 32'(if_d.c_out), 0);
        if_d.u = 1'b0; tick(2);
        if_d.u = 1'b1; tick(2);
        chk("d_after_clr", 32'(if_d.c_out), 1);
        if_d.u = 1'b0; tick(2);

        // Reset during INC on A discards the step
        chk("a_pre_rst", 32'(if_a.c_out), 1);
        if_a.u = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("a_rst_inc", 32'(if_a.c_out), 0);
        chk("a_rst_inc_z", 32'(if_a.z), 1);
        if_a.u = 1'b0;
        reset = 1'b0;
        tick(3);
        chk("a_post_rst", 32'(if_a.c_out), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_counter_sys.md
# updown_counter_sys

Parametrised successor to the current 16-bit up/down counter system (FSM plus datapath).

- Counts one step per button press on `u`/`d`, with configurable width, maximum value, step size and end-of-range mode (saturate or wrap).
- Adds press/release handshaking, optional auto-repeat while a button is held, a synchronous soft clear, and limit-event reporting.
- Sits between the debounced front-panel button inputs and the display/consumer logic.

## Interface
- `WIDTH`, 16: counter width in bits.
- `MAX_VAL`, 2**WIDTH-1: upper bound of count. Legal range 1 ≤ MAX_VAL ≤ 2**WIDTH-1.
- `STEP`, 1: increment/decrement amount. Legal range 1 ≤ STEP ≤ MAX_VAL.
- `WRAP`, 0: end-of-range mode. 0 = saturate; 1 = wrap modulo MAX_VAL+1.
- `REPEAT`, 0: hold cycles before each auto-repeat step. 0 = auto-repeat disabled.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `u` input 1: up request, level.
- `d` input 1: down request, level.
- `clr` input 1: synchronous soft clear, level.
- `c_out` output WIDTH: current count.
- `z` output 1: high when c_out == 0.
- `m` output 1: high when c_out == MAX_VAL.
- `lim` output 1: one-cycle pulse when a step hit or crossed a range end (saturated or wrapped).

## Operation
- **States:** INICIO, ESPERA, VERIFICA, INC, DEC, HOLD.
- **Reset:** on a clock edge with reset=1, state ← INICIO and c_out ← 0. Outputs after reset: z=1, m=0, lim=0.
- **Start-up:** INICIO asserts internal c_clr, then goes to ESPERA. ESPERA goes to VERIFICA unconditionally.
- **VERIFICA:**
  - u=1, d=0 → INC.
  - d=1, u=0 → DEC.
  - u=1, d=1 → HOLD, with no count change.
  - u=0, d=0 → stay in VERIFICA.
- **INC / DEC:** one cycle. Asserts c_ld with op=up/down, then goes to HOLD and clears the repeat timer.
- **HOLD:**
  - u=0 and d=0 → VERIFICA.
  - Otherwise, if REPEAT>0, the timer counts held cycles. When it reaches REPEAT-1, go to INC if only u is held, or DEC if only d is held. If both are held, the timer is held at 0.
- **Soft clear:** clr=1 in any non-reset state → c_out ← 0 and state ← HOLD. No step happens until both buttons are released. Priority: reset > clr > FSM.
- **Arithmetic:** computed in WIDTH+1 bits.
  - Up, saturate: if c_out > MAX_VAL-STEP, then c_out ← MAX_VAL and lim=1. This includes c_out already at MAX_VAL.
  - Up, wrap: on overflow, c_out ← c_out+STEP-(MAX_VAL+1) and lim=1.
  - Down, saturate: if c_out < STEP, then c_out ← 0 and lim=1.
  - Down, wrap: on underflow, c_out ← c_out+(MAX_VAL+1)-STEP and lim=1.
- **Flags:** z and m are combinational from the c_out register. lim is registered, aligned with the c_out update.

## Timing
- Press latency: u rising while in VERIFICA → INC on the next edge → c_out updated at the edge after that (2 cycles). lim is valid in that same cycle.
- A button held indefinitely with REPEAT=0 produces exactly one step.
- With REPEAT=N, the held-button step period is N+1 cycles: N HOLD cycles plus 1 INC/DEC cycle.
- Release latency: one cycle from u=d=0 in HOLD back to VERIFICA.
- Reset takes effect at the next edge, regardless of state. This includes mid-INC: that update is discarded.
- From reset deassertion: INICIO, ESPERA, VERIFICA. The first press is accepted 2 cycles after reset falls.

## Structure
- Package `updown_counter_pkg` holds:
  - the state enum/localparams (3-bit encoding);
  - the op encoding (OP_UP, OP_DOWN).
- Sub-module `updown_counter_dp` is the datapath: register, next-value arithmetic, z/m/lim. Control stays in the top module FSM.

## Test plan
- Reset then idle (WIDTH=16): reset high 10 cycles, release. c_out=0 and z=1 throughout; state reaches VERIFICA after 2 cycles.
- Single presses (STEP=1): u held 5 cycles, released, repeated twice. c_out=2. Then one d press → c_out=1. Each press yields exactly one step.
- Saturate bounds (WIDTH=4, MAX_VAL=9, STEP=4, WRAP=0):
  - presses u,u,u → 4, 8, 9; lim only on the third press.
  - at 0, a d press → c_out stays 0, lim=1, z=1.
- Wrap bounds (same parameters, WRAP=1):
  - 8 + u → 2 with lim=1.
  - 2 + d → 8 with lim=1.
- Auto-repeat (REPEAT=3): u held 20 cycles from VERIFICA. c_out increments at cycles 2, 6, 10, 14, 18, for a final value of 5.
- Simultaneous and clear:
  - u=d=1 → no change.
  - clr pulse at c_out=7 with u held → c_out=0 next cycle, and no further step until u is released and pressed again.
  - reset asserted during INC → c_out=0.
